uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of byte-stream requesters sharing the TX FIFO write port (range 2..8).
REQ-002 Parameter PAYLOAD_BITS, default 8: byte width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: maximum consecutive idle cycles allowed inside a granted packet.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester byte valid.
REQ-007 req_data  in  NUM_REQ*PAYLOAD_BITS  per-requester byte; requester i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-008 req_last  in  NUM_REQ  byte is final byte of packet.
REQ-009 req_ready  out  NUM_REQ  byte accepted this cycle when valid and ready are both high.
REQ-010 fifo_full  in  1  TX FIFO full flag.
REQ-011 fifo_write  out  1  TX FIFO write strobe.
REQ-012 fifo_write_data  out  PAYLOAD_BITS  TX FIFO write data.
REQ-013 grant  out  NUM_REQ  one-hot current owner; all zero when idle.
REQ-014 timeout_err  out  1  one-cycle pulse on packet abort.
REQ-015 timeout_id  out  clog2(NUM_REQ)  index of aborted requester; held until next abort.

Function
REQ-016 Two states: IDLE and BUSY.
REQ-017 IDLE: if any req_valid is high, select the first valid index at or after rr_ptr, wrapping modulo NUM_REQ; register grant; enter BUSY next cycle. Arbitration latency is exactly 1 cycle.
REQ-018 IDLE: grant=0, req_ready=0, fifo_write=0.
REQ-019 BUSY: req_ready[g] = ~fifo_full (combinational); req_ready of non-granted requesters = 0.
REQ-020 BUSY: fifo_write = req_valid[g] & ~fifo_full; fifo_write_data = req_data slice g; zero write latency.
REQ-021 Packet-atomic: grant is held from the first byte through acceptance of the byte with req_last=1; other requesters are never interleaved.
REQ-022 On acceptance of the last byte: next state IDLE, rr_ptr = (g+1) mod NUM_REQ; one idle bubble cycle between packets.
REQ-023 Single-byte packet (valid & last on first BUSY cycle) completes in one BUSY cycle.
REQ-024 Idle counter: increments in BUSY on cycles with req_valid[g]=0; clears on every accepted byte and on entering BUSY; cycles stalled by fifo_full with valid high do not count.
REQ-025 When the idle counter reaches TIMEOUT_CYCLES: pulse timeout_err for 1 cycle, load timeout_id=g, go to IDLE, rr_ptr=(g+1) mod NUM_REQ; the partial packet is not completed.
REQ-026 Counter width: clog2(TIMEOUT_CYCLES+1); saturation is unnecessary because the counter clears on abort.
REQ-027 req_valid deasserting mid-packet is legal; it only stalls the packet and advances the timeout count.

Reset
REQ-028 resetn low immediately forces: state IDLE, rr_ptr 0, grant 0, idle counter 0, timeout_err 0, timeout_id 0; combinational outputs req_ready and fifo_write are therefore 0.
REQ-029 Reset mid-packet truncates the packet silently; no timeout_err is generated.

Structure
REQ-030 State encoding localparams and default parameter values belong in the shared controller package.
REQ-031 The round-robin selection shall be one sub-module, rr_picker (inputs: request vector, pointer; outputs: valid flag, index).

Verification
REQ-032 Both requesters valid in IDLE with rr_ptr=0: req0 3-byte packet 0x11,0x22,0x33(last) is written first, then req1 packet 0xAA(last); FIFO order is 11 22 33 AA; next IDLE rr_ptr=0.
REQ-033 req1 asserts valid mid-packet of req0: no req1 byte is written until req0 last is accepted; req1 granted 2 cycles after req0 last (1 bubble cycle plus 1 arbitration cycle).
REQ-034 fifo_full held high 5 cycles during BUSY with valid high: fifo_write=0 and req_ready=0 throughout; no timeout; transfer resumes the cycle full drops.
REQ-035 TIMEOUT_CYCLES=4: req0 sends 1 byte then drops valid: timeout_err pulses on the 4th idle cycle, timeout_id=0, grant clears, and req1 (valid) is granted next.
REQ-036 resetn pulsed low mid-packet: grant=0, fifo_write=0 immediately, timeout_err stays 0; after release, arbitration restarts at rr_ptr=0.
REQ-037 NUM_REQ=3, all requesters issuing continuous single-byte packets: grants rotate 0,1,2,0, with no starvation.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// ============================================================================
// Module : uart_tx_arbiter_pkg
// Brief  : Shared defaults and controller state encoding for the TX arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_tx_arbiter_pkg;

    localparam int C_DEF_NUM_REQ        = 2;
    localparam int C_DEF_PAYLOAD_BITS   = 8;
    localparam int C_DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_picker.sv
// ============================================================================
// Module : rr_picker
// Brief  : Combinational round-robin pick of the first request at/after ptr_i.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = C_DEF_NUM_REQ,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic               valid_o,
    output logic [IDW-1:0]     idx_o
);

    logic [IDW-1:0] w_j;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        w_j     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = IDW'((int'(ptr_i) + k) % NUM_REQ);
            if (req_i[w_j]) begin
                valid_o = 1'b1;
                idx_o   = w_j;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module : uart_tx_arbiter
// Brief  : Packet-atomic round-robin arbiter feeding a shared UART TX FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int NUM_REQ        = C_DEF_NUM_REQ,
    parameter  int PAYLOAD_BITS   = C_DEF_PAYLOAD_BITS,
    parameter  int TIMEOUT_CYCLES = C_DEF_TIMEOUT_CYCLES,
    localparam int IDW            = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            fifo_full,
    output logic                            fifo_write,
    output logic [PAYLOAD_BITS-1:0]         fifo_write_data,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            timeout_err,
    output logic [IDW-1:0]                  timeout_id
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDW-1:0]     gidx_q;
    logic [IDW-1:0]     rr_ptr_q;
    logic [CW-1:0]      idle_cnt_q;
    logic               timeout_err_q;
    logic [IDW-1:0]     timeout_id_q;

    logic               w_pick_valid;
    logic [IDW-1:0]     w_pick_idx;
    logic               w_busy;
    logic               w_g_valid;
    logic               w_g_last;
    logic               w_accept;
    logic               w_idle_cyc;
    logic               w_expire;
    logic [IDW-1:0]     w_next_ptr;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_picker (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .valid_o (w_pick_valid),
        .idx_o   (w_pick_idx)
    );

    assign w_busy     = (state_q == ST_BUSY);
    assign w_g_valid  = req_valid[gidx_q];
    assign w_g_last   = req_last[gidx_q];
    assign w_accept   = w_busy & w_g_valid & ~fifo_full;
    // A stall caused only by fifo_full is not an idle cycle.
    assign w_idle_cyc = w_busy & ~w_g_valid;
    assign w_expire   = w_idle_cyc & (idle_cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign w_next_ptr = (gidx_q == IDW'(NUM_REQ - 1)) ? '0 : gidx_q + IDW'(1);

    assign req_ready       = grant_q & {NUM_REQ{~fifo_full}};
    assign fifo_write      = w_accept;
    assign fifo_write_data = req_data[gidx_q*PAYLOAD_BITS +: PAYLOAD_BITS];
    assign grant           = grant_q;
    assign timeout_err     = timeout_err_q;
    assign timeout_id      = timeout_id_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            gidx_q        <= '0;
            rr_ptr_q      <= '0;
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            timeout_id_q  <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        state_q    <= ST_BUSY;
                        grant_q    <= NUM_REQ'(1) << w_pick_idx;
                        gidx_q     <= w_pick_idx;
                        idle_cnt_q <= '0;
                    end
                end
                ST_BUSY: begin
                    if (w_accept) begin
                        idle_cnt_q <= '0;
                        if (w_g_last) begin
                            state_q  <= ST_IDLE;
                            grant_q  <= '0;
                            rr_ptr_q <= w_next_ptr;
                        end
                    end else if (w_expire) begin
                        state_q       <= ST_IDLE;
                        grant_q       <= '0;
                        rr_ptr_q      <= w_next_ptr;
                        idle_cnt_q    <= '0;
                        timeout_err_q <= 1'b1;
                        timeout_id_q  <= gidx_q;
                    end else if (w_idle_cyc) begin
                        idle_cnt_q <= idle_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module : tb_uart_tx_arbiter
// Brief  : Self-checking bench: packet-level owner model plus pinned scenarios.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic full2 = 1'b0;
    logic full3 = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a2_v [2];
    logic [7:0] a2_d [2];
    logic       a2_l [2];
    logic       a3_v [3];
    logic [7:0] a3_d [3];
    logic       a3_l [3];

    logic [1:0]  v2, l2, rdy2, gnt2;
    logic [15:0] d2;
    logic        wr2, err2, tid2;
    logic [7:0]  wd2;
    logic [2:0]  v3, l3, rdy3, gnt3;
    logic [23:0] d3;
    logic        wr3, err3;
    logic [1:0]  tid3;
    logic [7:0]  wd3;

    assign v2 = {a2_v[1], a2_v[0]};
    assign l2 = {a2_l[1], a2_l[0]};
    assign d2 = {a2_d[1], a2_d[0]};
    assign v3 = {a3_v[2], a3_v[1], a3_v[0]};
    assign l3 = {a3_l[2], a3_l[1], a3_l[0]};
    assign d3 = {a3_d[2], a3_d[1], a3_d[0]};

    uart_tx_arbiter #(.NUM_REQ(2), .PAYLOAD_BITS(8), .TIMEOUT_CYCLES(TMO)) dut2 (
        .clk(clk), .resetn(resetn), .req_valid(v2), .req_data(d2), .req_last(l2),
        .req_ready(rdy2), .fifo_full(full2), .fifo_write(wr2), .fifo_write_data(wd2),
        .grant(gnt2), .timeout_err(err2), .timeout_id(tid2)
    );

    uart_tx_arbiter #(.NUM_REQ(3), .PAYLOAD_BITS(8), .TIMEOUT_CYCLES(TMO)) dut3 (
        .clk(clk), .resetn(resetn), .req_valid(v3), .req_data(d3), .req_last(l3),
        .req_ready(rdy3), .fifo_full(full3), .fifo_write(wr3), .fifo_write_data(wd3),
        .grant(gnt3), .timeout_err(err3), .timeout_id(tid3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state per instance: owner (-1 = nobody), next pointer, idle run.
    int m_own [2] = '{-1, -1};
    int m_ptr [2] = '{0, 0};
    int m_idle[2] = '{0, 0};
    int m_err [2] = '{0, 0};
    int m_tid [2] = '{0, 0};

    task automatic model_cmp(input int k, input int n, input logic [2:0] v,
                             input logic [23:0] d, input logic [2:0] l, input logic full,
                             input logic [2:0] g, input logic [2:0] rdy, input logic wr,
                             input logic [7:0] wd, input logic err, input logic [1:0] tid);
        int    eg, ew, own;
        string s;
        s = (k == 0) ? "n2" : "n3";
        if (!resetn) begin
            m_own[k] = -1; m_ptr[k] = 0; m_idle[k] = 0; m_err[k] = 0; m_tid[k] = 0;
        end
        own = m_own[k];
        eg  = (own >= 0) ? (1 << own) : 0;
        ew  = (own >= 0 && v[own] && !full) ? 1 : 0;
        check({s, ".grant"},      int'(g),   eg);
        check({s, ".req_ready"},  int'(rdy), full ? 0 : eg);
        check({s, ".fifo_write"}, int'(wr),  ew);
        if (ew == 1) check({s, ".wdata"}, int'(wd), int'(d[own*8 +: 8]));
        check({s, ".timeout_err"}, int'(err), m_err[k]);
        check({s, ".timeout_id"},  int'(tid), m_tid[k]);
        if (!resetn) return;
        m_err[k] = 0;
        if (own < 0) begin
            for (int i = 0; i < n; i++) begin
                if (v[(m_ptr[k] + i) % n]) begin
                    m_own[k]  = (m_ptr[k] + i) % n;
                    m_idle[k] = 0;
                    break;
                end
            end
        end else if (ew == 1) begin
            m_idle[k] = 0;
            if (l[own]) begin
                m_ptr[k] = (own + 1) % n;
                m_own[k] = -1;
            end
        end else if (!v[own]) begin
            m_idle[k]++;
            if (m_idle[k] == TMO) begin
                m_err[k] = 1; m_tid[k] = own; m_ptr[k] = (own + 1) % n;
                m_own[k] = -1; m_idle[k] = 0;
            end
        end
    endtask

    logic [7:0] w2_d[$];
    int         w2_c[$];
    logic [7:0] w3_d[$];
    int         e_c[$];
    int         e_id[$];

    always @(negedge clk) begin
        model_cmp(0, 2, {1'b0, v2}, {8'h00, d2}, {1'b0, l2}, full2, {1'b0, gnt2},
                  {1'b0, rdy2}, wr2, wd2, err2, {1'b0, tid2});
        model_cmp(1, 3, v3, d3, l3, full3, gnt3, rdy3, wr3, wd3, err3, tid3);
        if (resetn && wr2) begin w2_d.push_back(wd2); w2_c.push_back(cyc); end
        if (resetn && wr3) w3_d.push_back(wd3);
        if (err2) begin e_c.push_back(cyc); e_id.push_back(int'(tid2)); end
    end

    function automatic int find_cyc(input logic [7:0] b);
        foreach (w2_d[i]) if (w2_d[i] == b) return w2_c[i];
        return -1000;
    endfunction

    task automatic drive(input int k, input int r, input logic v, input logic [7:0] d, input logic l);
        if (k == 0) begin a2_v[r] = v; a2_d[r] = d; a2_l[r] = l; end
        else        begin a3_v[r] = v; a3_d[r] = d; a3_l[r] = l; end
    endtask

    function automatic logic rdy(input int k, input int r);
        return (k == 0) ? rdy2[r] : rdy3[r];
    endfunction

    // Called just after a rising edge; returns just after the edge that took the final byte.
    task automatic send(input int k, input int r, input logic [7:0] q[$], input logic end_last);
        logic ok;
        for (int i = 0; i < q.size(); i++) begin
            drive(k, r, 1'b1, q[i], (i == q.size() - 1) ? end_last : 1'b0);
            ok = 1'b0;
            for (int c = 0; c < 100 && !ok; c++) begin
                @(negedge clk);
                ok = rdy(k, r);
                @(posedge clk); #1;
            end
            if (!ok) begin
                n_checks++; n_fail++;
                $display("FAIL handshake: inst %0d req %0d byte %0d not accepted, expected within 100 cycles", k, r, i);
                drive(k, r, 1'b0, 8'h00, 1'b0);
                return;
            end
        end
        drive(k, r, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] exp_a[4];
        int c;
        exp_a = '{8'h11, 8'h22, 8'h33, 8'hAA};
        for (int i = 0; i < 2; i++) drive(0, i, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) drive(1, i, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        check("reset_grant", int'(gnt2), 0);
        check("reset_tid",   int'(tid2), 0);
        @(posedge clk); #1;

        // Both requesters pending from rr_ptr 0: whole req0 packet precedes req1.
        fork
            send(0, 0, '{8'h11, 8'h22, 8'h33}, 1'b1);
            send(0, 1, '{8'hAA}, 1'b1);
        join
        check("order_count", w2_d.size(), 4);
        for (int i = 0; i < 4; i++)
            check("order_byte", (w2_d.size() > i) ? int'(w2_d[i]) : -1, int'(exp_a[i]));

        // req1 arrives mid-packet: granted two cycles after req0's last byte.
        fork
            send(0, 0, '{8'h01, 8'h02, 8'h03}, 1'b1);
            begin repeat (2) @(posedge clk); #1; send(0, 1, '{8'h04}, 1'b1); end
        join
        check("burst_span",   find_cyc(8'h03) - find_cyc(8'h01), 2);
        check("rearb_latency", find_cyc(8'h04) - find_cyc(8'h03), 2);

        // FIFO full for 5 cycles inside a packet.
        fork
            send(0, 0, '{8'h41, 8'h42, 8'h43}, 1'b1);
            begin
                repeat (2) @(posedge clk); #1 full2 = 1'b1;
                repeat (5) @(posedge clk); #1 full2 = 1'b0;
            end
        join
        check("stall_resume", find_cyc(8'h42) - find_cyc(8'h41), 6);
        check("stall_span",   find_cyc(8'h43) - find_cyc(8'h41), 7);
        check("stall_no_tmo", e_c.size(), 0);

        // Abandoned packet from req0 times out; waiting req1 then wins.
        fork
            send(0, 0, '{8'h55}, 1'b0);
            begin repeat (2) @(posedge clk); #1; send(0, 1, '{8'h66}, 1'b1); end
        join
        c = find_cyc(8'h55);
        check("tmo_count", e_c.size(), 1);
        check("tmo_cycle", (e_c.size() > 0) ? e_c[0] - c : -1, 5);
        check("tmo_id",    (e_id.size() > 0) ? e_id[0] : -1, 0);
        check("tmo_next",  find_cyc(8'h66) - c, 6);

        // Reset mid-packet with req1 owning and writing; pointer must restart at 0.
        send(0, 0, '{8'h77}, 1'b1);
        send(0, 1, '{8'h88}, 1'b0);
        drive(0, 1, 1'b1, 8'h99, 1'b1);
        drive(0, 0, 1'b1, 8'hA0, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("rst_grant",  int'(gnt2), 0);
        check("rst_write",  int'(wr2),  0);
        check("rst_ready",  int'(rdy2), 0);
        check("rst_err",    int'(err2), 0);
        @(posedge clk); #1 resetn = 1'b1;
        fork
            send(0, 0, '{8'hA0}, 1'b1);
            send(0, 1, '{8'h99}, 1'b1);
        join
        check("rst_restart", find_cyc(8'h99) - find_cyc(8'hA0), 2);
        check("rst_no_tmo",  e_c.size(), 1);

        // Three requesters streaming single-byte packets rotate fairly.
        fork
            begin for (int k = 0; k < 4; k++) send(1, 0, '{8'(8'h10 + k)}, 1'b1); end
            begin for (int k = 0; k < 4; k++) send(1, 1, '{8'(8'h20 + k)}, 1'b1); end
            begin for (int k = 0; k < 4; k++) send(1, 2, '{8'(8'h30 + k)}, 1'b1); end
        join
        check("rot_count", w3_d.size(), 12);
        for (int i = 0; i < 12; i++)
            check("rot_byte", (w3_d.size() > i) ? int'(w3_d[i]) : -1, 16 * (i % 3 + 1) + i / 3);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time %0t exceeded, expected completion earlier", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
